cache_evict_ctrl: RTL and testbench
===================================

# cache_evict_ctrl

Per-set eviction and fill controller sitting directly downstream of the cache line state FSM (PTC/D/V bits). On a miss it inspects the victim line's state and waits out any pending commit. If the line is valid and dirty, it serializes the line to memory, then issues the refill read and reassembles the returned beats. It drives the extract, writeback and enable strobes back into the line state FSM so the V/D/PTC bits track the eviction.

## Interface
- ADDR_BITS, 32, byte address width
- LINE_BITS, 128, cache line width
- BUS_BITS, 32, memory data bus width; LINE_BITS must be a multiple of BUS_BITS; BEATS = LINE_BITS/BUS_BITS

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- evict_req  in  1  start eviction/refill; sampled only in IDLE
- victim_addr  in  ADDR_BITS  line-aligned victim address
- fill_addr  in  ADDR_BITS  line-aligned refill address
- line_v, line_d, line_ptc  in  1 each  victim state bits from the line state FSM, sampled live
- line_data  in  LINE_BITS  victim line contents
- evict_busy  out  1  high whenever state is not IDLE
- fsm_extract  out  1  one-cycle pulse: victim extracted
- fsm_wb  out  1  one-cycle pulse: writeback complete
- fsm_enable  out  1  high in exactly the cycles where fsm_extract or fsm_wb is high
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1 = write beat, 0 = line read
- mem_req_addr  out  ADDR_BITS  request address
- mem_req_wdata  out  BUS_BITS  write beat data
- mem_rsp_valid  in  1  read beat valid
- mem_rsp_rdata  in  BUS_BITS  read beat data
- fill_valid  out  1  one-cycle pulse: fill_data complete
- fill_data  out  LINE_BITS  assembled refill line

## Operation
- States: IDLE, CHECK, WB, FILL_REQ, FILL_RSP, DONE.
- IDLE: on evict_req, latch victim_addr and fill_addr, then go to CHECK. evict_req in any other state is ignored.
- CHECK:
  - line_ptc=1: stay in CHECK (stall on pending commit).
  - Else, if line_v & line_d: capture line_data, pulse fsm_extract, go to WB.
  - Else: go to FILL_REQ with no writeback.
- WB: issue BEATS write requests, low word first. Beat k has address victim_addr + k*(BUS_BITS/8) and data line[k*BUS_BITS +: BUS_BITS]. A beat advances only on mem_req_valid & mem_req_ready. The cycle after the last beat handshake, pulse fsm_wb and go to FILL_REQ.
- FILL_REQ: one read request, mem_req_we=0, addr=fill_addr. Hold it until ready, then go to FILL_RSP.
- FILL_RSP: collect BEATS responses into fill_data, beat k into slice k, in arrival order. After the last beat, go to DONE.
- DONE: fill_valid=1 for one cycle, then IDLE.
- mem_rsp_valid outside FILL_RSP is ignored.
- mem_req_valid, once raised, holds with stable addr/data/we until accepted.
- Beat counter width is clog2(BEATS) and wraps to 0 at each phase start.

## Timing
- Reset: state IDLE. All outputs 0: evict_busy, fsm_*, mem_req_*, fill_valid, fill_data. Beat counter 0.
- evict_req at cycle 0 → CHECK and evict_busy=1 at cycle 1.
- CHECK takes a minimum of 1 cycle. Clean victim with zero-wait memory: read request at cycle 2, fill_valid at cycle 2+1+BEATS (earliest, if first response arrives the cycle after accept).
- Dirty victim, always-ready memory: write beats at cycles 2..1+BEATS, fsm_wb at 2+BEATS, read request at 3+BEATS.
- Reset mid-operation: immediate return to IDLE. In-flight request dropped, partial fill discarded, no fsm_* pulse.
- line_ptc falling in CHECK: act on the same cycle's line_v/line_d.

## Structure
- Shared package cache_pkg: state enum, BEATS and beat-index width as localparams, and the line/beat slice helper function.
- One sub-module, cache_line_serdes: a BEATS-deep parallel-load/shift line buffer used both to serialize WB beats and to assemble FILL_RSP beats.

## Test plan
- Clean miss (v=1, d=0, ptc=0), fill_addr=0x100, responses 0x11,0x22,0x33,0x44 → no write beats, one read at 0x100, fill_data=0x00000044_00000033_00000022_00000011, fill_valid single pulse.
- Dirty miss, victim_addr=0x200, line_data=0xDDDD_CCCC_BBBB_AAAA_… → writes to 0x200/204/208/20C with low word first; fsm_extract at CHECK exit and fsm_wb once, each with fsm_enable.
- ptc=1 for 5 cycles, then 0 → stays in CHECK 5 cycles, no memory activity; proceeds on the first ptc=0 cycle.
- Dirty miss with mem_req_ready low for 3 cycles on beat 2 → beat 2 addr/data stable throughout, no skipped or duplicated beats.
- rst asserted during FILL_RSP after 2 beats → next cycle all outputs 0 and state IDLE. A fresh request completes correctly with no leftover beats.
- evict_req held high during busy plus stray mem_rsp_valid in WB → exactly one operation, stray data absent from fill_data.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared definitions for the eviction/fill controller.
//   - evict_state_e : controller state encoding
//   - *_DEF         : default geometry (32-bit address, 128-bit line, 32-bit bus)
//   - BEATS/BEAT_W  : bus beats per line and beat-index width for the defaults
//   - beat_lsb()    : bit position of beat k inside a line (also yields byte offsets)
package cache_pkg;

    localparam int unsigned ADDR_BITS_DEF = 32;
    localparam int unsigned LINE_BITS_DEF = 128;
    localparam int unsigned BUS_BITS_DEF  = 32;
    localparam int unsigned BEATS         = LINE_BITS_DEF / BUS_BITS_DEF;
    localparam int unsigned BEAT_W        = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_WB       = 3'd2,
        ST_FILL_REQ = 3'd3,
        ST_FILL_RSP = 3'd4,
        ST_DONE     = 3'd5
    } evict_state_e;

    // Lowest bit of beat idx within a line for a bus of bus_bits width.
    function automatic int unsigned beat_lsb(input int unsigned idx, input int unsigned bus_bits);
        return idx * bus_bits;
    endfunction

endpackage

// File: rtl/cache_line_serdes.sv
// cache_line_serdes: line-wide buffer that either parallel-loads a whole line
// or shifts one bus beat per step. Shifting moves data toward the low end and
// inserts shift_in at the top, so:
//   - after a load, beat_out presents beats low word first as it shifts;
//   - after BEATS shifts of incoming data, the first beat sits in slice 0.
// Ports: clk, rst (async, active-high), load_en/load_line, shift_en/shift_in,
//        line_q (whole buffer), beat_out (lowest beat).
module cache_line_serdes #(
    parameter int unsigned LINE_BITS = 128,
    parameter int unsigned BUS_BITS  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_en,
    input  logic [LINE_BITS-1:0] load_line,
    input  logic                 shift_en,
    input  logic [BUS_BITS-1:0]  shift_in,
    output logic [LINE_BITS-1:0] line_q,
    output logic [BUS_BITS-1:0]  beat_out
);

    logic [LINE_BITS-1:0] line_d;

    // Next buffer contents: load wins over shift.
    always_comb begin
        line_d = line_q;
        if (load_en) begin
            line_d = load_line;
        end else if (shift_en) begin
            line_d = {shift_in, line_q[LINE_BITS-1:BUS_BITS]};
        end else begin
            line_d = line_q;
        end
    end

    // Buffer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= {LINE_BITS{1'b0}};
        end else begin
            line_q <= line_d;
        end
    end

    assign beat_out = line_q[BUS_BITS-1:0];

endmodule

// File: rtl/cache_evict_ctrl.sv
// cache_evict_ctrl: per-set eviction and refill controller.
// On evict_req it waits out a pending commit (line_ptc), writes a valid+dirty
// victim back beat by beat, issues one line read for the refill address, and
// assembles the returned beats into fill_data.
// Ports:
//   evict_req, victim_addr, fill_addr        : request from the set logic
//   line_v/line_d/line_ptc, line_data        : live victim state and data
//   evict_busy, fsm_extract, fsm_wb, fsm_enable : status/strobes to line FSM
//   mem_req_* / mem_rsp_*                    : memory request/response bus
//   fill_valid, fill_data                    : completed refill line
module cache_evict_ctrl
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_BITS = ADDR_BITS_DEF,
    parameter int unsigned LINE_BITS = LINE_BITS_DEF,
    parameter int unsigned BUS_BITS  = BUS_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 evict_req,
    input  logic [ADDR_BITS-1:0] victim_addr,
    input  logic [ADDR_BITS-1:0] fill_addr,
    input  logic                 line_v,
    input  logic                 line_d,
    input  logic                 line_ptc,
    input  logic [LINE_BITS-1:0] line_data,
    output logic                 evict_busy,
    output logic                 fsm_extract,
    output logic                 fsm_wb,
    output logic                 fsm_enable,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic                 mem_req_we,
    output logic [ADDR_BITS-1:0] mem_req_addr,
    output logic [BUS_BITS-1:0]  mem_req_wdata,
    input  logic                 mem_rsp_valid,
    input  logic [BUS_BITS-1:0]  mem_rsp_rdata,
    output logic                 fill_valid,
    output logic [LINE_BITS-1:0] fill_data
);

    localparam int unsigned NBEATS = LINE_BITS / BUS_BITS;
    localparam int unsigned IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    evict_state_e         state_q, state_d;
    logic [ADDR_BITS-1:0] victim_addr_q, victim_addr_d;
    logic [ADDR_BITS-1:0] fill_addr_q, fill_addr_d;
    logic [IDX_W-1:0]     beat_q, beat_d;
    logic                 fsm_extract_q, fsm_extract_d;
    logic                 fsm_wb_q, fsm_wb_d;
    logic                 fsm_enable_q, fsm_enable_d;
    logic                 fill_valid_q, fill_valid_d;

    logic                 ser_load;
    logic                 ser_shift;
    logic [BUS_BITS-1:0]  ser_in;
    logic [LINE_BITS-1:0] ser_line;
    logic [BUS_BITS-1:0]  ser_beat;
    logic                 req_fire;
    logic                 last_beat;
    logic                 wb_active;
    logic [ADDR_BITS-1:0] beat_off;

    cache_line_serdes #(
        .LINE_BITS (LINE_BITS),
        .BUS_BITS  (BUS_BITS)
    ) u_serdes (
        .clk       (clk),
        .rst       (rst),
        .load_en   (ser_load),
        .load_line (line_data),
        .shift_en  (ser_shift),
        .shift_in  (ser_in),
        .line_q    (ser_line),
        .beat_out  (ser_beat)
    );

    // WB keeps one tail cycle after the last beat (fsm_wb high) with no request.
    assign wb_active = (state_q == ST_WB) && !fsm_wb_q;
    assign req_fire  = mem_req_valid && mem_req_ready;
    assign last_beat = (beat_q == IDX_W'(NBEATS - 1));
    assign beat_off  = ADDR_BITS'(beat_lsb(32'(beat_q), BUS_BITS) / 32'd8);

    // Next-state, beat counter and strobe computation.
    always_comb begin
        state_d       = state_q;
        victim_addr_d = victim_addr_q;
        fill_addr_d   = fill_addr_q;
        beat_d        = beat_q;
        fsm_extract_d = 1'b0;
        fsm_wb_d      = 1'b0;
        fill_valid_d  = 1'b0;
        ser_load      = 1'b0;
        ser_shift     = 1'b0;
        ser_in        = mem_rsp_rdata;
        case (state_q)
            ST_IDLE: begin
                if (evict_req) begin
                    victim_addr_d = victim_addr;
                    fill_addr_d   = fill_addr;
                    beat_d        = {IDX_W{1'b0}};
                    state_d       = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                // A pending commit freezes the decision; once it drops the
                // same cycle's V/D bits choose the path.
                if (line_ptc) begin
                    state_d = ST_CHECK;
                end else if (line_v && line_d) begin
                    ser_load      = 1'b1;
                    fsm_extract_d = 1'b1;
                    beat_d        = {IDX_W{1'b0}};
                    state_d       = ST_WB;
                end else begin
                    beat_d  = {IDX_W{1'b0}};
                    state_d = ST_FILL_REQ;
                end
            end
            ST_WB: begin
                if (fsm_wb_q) begin
                    beat_d  = {IDX_W{1'b0}};
                    state_d = ST_FILL_REQ;
                end else if (req_fire) begin
                    ser_shift = 1'b1;
                    ser_in    = {BUS_BITS{1'b0}};
                    if (last_beat) begin
                        fsm_wb_d = 1'b1;
                        beat_d   = {IDX_W{1'b0}};
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_FILL_REQ: begin
                if (mem_req_ready) begin
                    beat_d  = {IDX_W{1'b0}};
                    state_d = ST_FILL_RSP;
                end else begin
                    state_d = ST_FILL_REQ;
                end
            end
            ST_FILL_RSP: begin
                if (mem_rsp_valid) begin
                    ser_shift = 1'b1;
                    if (last_beat) begin
                        fill_valid_d = 1'b1;
                        beat_d       = {IDX_W{1'b0}};
                        state_d      = ST_DONE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end else begin
                    state_d = ST_FILL_RSP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        fsm_enable_d = fsm_extract_d || fsm_wb_d;
    end

    // State, latched addresses, beat counter and registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            victim_addr_q <= {ADDR_BITS{1'b0}};
            fill_addr_q   <= {ADDR_BITS{1'b0}};
            beat_q        <= {IDX_W{1'b0}};
            fsm_extract_q <= 1'b0;
            fsm_wb_q      <= 1'b0;
            fsm_enable_q  <= 1'b0;
            fill_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            victim_addr_q <= victim_addr_d;
            fill_addr_q   <= fill_addr_d;
            beat_q        <= beat_d;
            fsm_extract_q <= fsm_extract_d;
            fsm_wb_q      <= fsm_wb_d;
            fsm_enable_q  <= fsm_enable_d;
            fill_valid_q  <= fill_valid_d;
        end
    end

    // Memory request decode; depends only on registered state so it holds
    // steady until accepted.
    always_comb begin
        mem_req_addr = {ADDR_BITS{1'b0}};
        case (state_q)
            ST_WB: begin
                if (wb_active) begin
                    mem_req_addr = victim_addr_q + beat_off;
                end else begin
                    mem_req_addr = {ADDR_BITS{1'b0}};
                end
            end
            ST_FILL_REQ: begin
                mem_req_addr = fill_addr_q;
            end
            default: begin
                mem_req_addr = {ADDR_BITS{1'b0}};
            end
        endcase
    end

    assign mem_req_valid = wb_active || (state_q == ST_FILL_REQ);
    assign mem_req_we    = wb_active;
    assign mem_req_wdata = wb_active ? ser_beat : {BUS_BITS{1'b0}};
    assign evict_busy    = (state_q != ST_IDLE);
    assign fsm_extract   = fsm_extract_q;
    assign fsm_wb        = fsm_wb_q;
    assign fsm_enable    = fsm_enable_q;
    assign fill_valid    = fill_valid_q;
    assign fill_data     = ser_line;

endmodule

// File: tb/tb_cache_evict_ctrl.sv
// Randomized self-checking bench for cache_evict_ctrl. Each operation is
// predicted from the rules of the block: a dirty victim produces BEATS writes
// at victim+4k carrying word k, then one read at fill_addr; the fill line is the
// response words packed low-first. Inputs change on the falling edge, outputs
// are sampled on the falling edge.
module tb_cache_evict_ctrl;

    localparam int ADDR_BITS = 32;
    localparam int LINE_BITS = 128;
    localparam int BUS_BITS  = 32;
    localparam int NB        = LINE_BITS / BUS_BITS;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 evict_req;
    logic [ADDR_BITS-1:0] victim_addr;
    logic [ADDR_BITS-1:0] fill_addr;
    logic                 line_v, line_d, line_ptc;
    logic [LINE_BITS-1:0] line_data;
    logic                 evict_busy, fsm_extract, fsm_wb, fsm_enable;
    logic                 mem_req_valid, mem_req_ready, mem_req_we;
    logic [ADDR_BITS-1:0] mem_req_addr;
    logic [BUS_BITS-1:0]  mem_req_wdata;
    logic                 mem_rsp_valid;
    logic [BUS_BITS-1:0]  mem_rsp_rdata;
    logic                 fill_valid;
    logic [LINE_BITS-1:0] fill_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cache_evict_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .evict_req     (evict_req),
        .victim_addr   (victim_addr),
        .fill_addr     (fill_addr),
        .line_v        (line_v),
        .line_d        (line_d),
        .line_ptc      (line_ptc),
        .line_data     (line_data),
        .evict_busy    (evict_busy),
        .fsm_extract   (fsm_extract),
        .fsm_wb        (fsm_wb),
        .fsm_enable    (fsm_enable),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .fill_valid    (fill_valid),
        .fill_data     (fill_data)
    );

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_busy"},   128'(evict_busy),    128'(0));
        check_val({tag, "_ext"},    128'(fsm_extract),   128'(0));
        check_val({tag, "_wb"},     128'(fsm_wb),        128'(0));
        check_val({tag, "_en"},     128'(fsm_enable),    128'(0));
        check_val({tag, "_rqv"},    128'(mem_req_valid), 128'(0));
        check_val({tag, "_rqwe"},   128'(mem_req_we),    128'(0));
        check_val({tag, "_rqa"},    128'(mem_req_addr),  128'(0));
        check_val({tag, "_rqd"},    128'(mem_req_wdata), 128'(0));
        check_val({tag, "_fv"},     128'(fill_valid),    128'(0));
        check_val({tag, "_fd"},     fill_data,           128'(0));
    endtask

    // One eviction/refill operation. ready_pct/rsp_pct: per-cycle probability
    // of ready / response. stall_beat >= 0 holds ready low 3 cycles on that
    // write beat. abort_after >= 0 resets after that many response beats.
    task automatic run_op(input logic v, input logic d, input int ptc_n,
                          input logic [31:0] vaddr, input logic [31:0] faddr,
                          input logic [127:0] line, input logic [127:0] rsp_line,
                          input int ready_pct, input int rsp_pct,
                          input bit hold_req, input bit stray,
                          input int stall_beat, input int abort_after);
        logic [31:0] exp_wa[$];
        logic [31:0] exp_wd[$];
        bit   dirty, fast, done, fv_seen, rsp_active, pend, aborted;
        int   reads, ext_n, wb_n, fv_n, beats_sent, wr_idx, stall_cnt, cyc;
        logic [31:0] p_addr, p_data;
        logic        p_we;
        logic        rdy;

        dirty = v & d;
        fast  = (ready_pct == 100) && (rsp_pct == 100) && (stall_beat < 0);
        if (dirty) begin
            for (int k = 0; k < NB; k++) begin
                exp_wa.push_back(vaddr + 32'(4 * k));
                exp_wd.push_back(line[k*32 +: 32]);
            end
        end
        done = 0; fv_seen = 0; rsp_active = 0; pend = 0; aborted = 0;
        reads = 0; ext_n = 0; wb_n = 0; fv_n = 0; beats_sent = 0;
        wr_idx = 0; stall_cnt = 0;
        p_addr = 32'd0; p_data = 32'd0; p_we = 1'b0;

        @(negedge clk);
        evict_req = 1'b1; victim_addr = vaddr; fill_addr = faddr;
        line_v = v; line_d = d; line_data = line; line_ptc = (ptc_n > 0);
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;

        for (cyc = 1; cyc < 400 && !done && !aborted; cyc++) begin
            @(negedge clk);
            if (!hold_req) evict_req = 1'b0;
            line_ptc = (cyc <= ptc_n);
            if (fv_seen) begin
                check_val("idle_after_fill", 128'(evict_busy), 128'(0));
                check_val("fill_pulse_once", 128'(fill_valid), 128'(0));
                done = 1;
            end else begin
                if (cyc == 1) check_val("busy_after_req", 128'(evict_busy), 128'(1));
                if (cyc >= 2 && cyc <= ptc_n) begin
                    check_val("ptc_no_req", 128'(mem_req_valid), 128'(0));
                    check_val("ptc_busy", 128'(evict_busy), 128'(1));
                end
                if (pend) begin
                    check_val("hold_valid", 128'(mem_req_valid), 128'(1));
                    check_val("hold_addr", 128'(mem_req_addr), 128'(p_addr));
                    check_val("hold_data", 128'(mem_req_wdata), 128'(p_data));
                    check_val("hold_we", 128'(mem_req_we), 128'(p_we));
                end
                check_val("enable_match", 128'(fsm_enable), 128'(fsm_extract | fsm_wb));
                ext_n += int'(fsm_extract);
                wb_n  += int'(fsm_wb);
                if (fsm_wb && fast) check_val("wb_cycle", 128'(cyc), 128'(2 + NB + ptc_n));
                if (fill_valid) begin
                    fv_n++;
                    fv_seen = 1;
                    evict_req = 1'b0;
                    check_val("fill_data", fill_data, rsp_line);
                    if (fast) check_val("fill_cycle", 128'(cyc),
                                        128'(dirty ? (4 + 2*NB + ptc_n) : (3 + NB + ptc_n)));
                end
                if (abort_after >= 0 && rsp_active && beats_sent == abort_after) begin
                    rst = 1'b1; mem_rsp_valid = 1'b0; mem_req_ready = 1'b0; evict_req = 1'b0;
                    #1;
                    check_quiet("rst_mid");
                    @(negedge clk);
                    check_quiet("rst_hold");
                    rst = 1'b0;
                    aborted = 1;
                end else begin
                    // response / stray data drive
                    if (rsp_active && beats_sent < NB) begin
                        if ($urandom_range(99) < rsp_pct) begin
                            mem_rsp_valid = 1'b1;
                            mem_rsp_rdata = rsp_line[beats_sent*32 +: 32];
                            beats_sent++;
                        end else begin
                            mem_rsp_valid = 1'b0;
                            mem_rsp_rdata = $urandom;
                        end
                    end else if (stray && !rsp_active && evict_busy && ($urandom_range(1) == 1)) begin
                        mem_rsp_valid = 1'b1;
                        mem_rsp_rdata = $urandom;
                    end else begin
                        mem_rsp_valid = 1'b0;
                    end
                    // ready decision and handshake accounting
                    if (mem_req_valid && mem_req_we && wr_idx == stall_beat && stall_cnt < 3) begin
                        rdy = 1'b0;
                        stall_cnt++;
                    end else begin
                        rdy = ($urandom_range(99) < ready_pct);
                    end
                    mem_req_ready = rdy;
                    pend = mem_req_valid && !rdy;
                    p_addr = mem_req_addr; p_data = mem_req_wdata; p_we = mem_req_we;
                    if (mem_req_valid && rdy) begin
                        if (mem_req_we) begin
                            if (exp_wa.size() == 0) begin
                                check_val("unexpected_write", 128'(mem_req_addr), 128'hFFFF_FFFF);
                            end else begin
                                check_val("wr_addr", 128'(mem_req_addr), 128'(exp_wa.pop_front()));
                                check_val("wr_data", 128'(mem_req_wdata), 128'(exp_wd.pop_front()));
                                if (fast && wr_idx == 0) check_val("wr_first_cycle", 128'(cyc), 128'(2 + ptc_n));
                                wr_idx++;
                            end
                        end else begin
                            reads++;
                            check_val("rd_addr", 128'(mem_req_addr), 128'(faddr));
                            check_val("rd_after_writes", 128'(exp_wa.size()), 128'(0));
                            if (fast) check_val("rd_cycle", 128'(cyc),
                                                128'(dirty ? (3 + NB + ptc_n) : (2 + ptc_n)));
                            rsp_active = 1;
                        end
                    end
                end
            end
        end
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; evict_req = 1'b0; line_ptc = 1'b0;
        if (!aborted) begin
            check_val("op_complete", 128'(done), 128'(1));
            check_val("writes_left", 128'(exp_wa.size()), 128'(0));
            check_val("read_count", 128'(reads), 128'(1));
            check_val("extract_count", 128'(ext_n), 128'(dirty));
            check_val("wb_count", 128'(wb_n), 128'(dirty));
            check_val("fill_count", 128'(fv_n), 128'(1));
        end
    endtask

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        rst = 1'b1; evict_req = 1'b0; victim_addr = 32'd0; fill_addr = 32'd0;
        line_v = 1'b0; line_d = 1'b0; line_ptc = 1'b0; line_data = 128'd0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = 32'd0;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;
        @(negedge clk);

        // clean miss, fixed responses
        run_op(1'b1, 1'b0, 0, 32'h0000_0300, 32'h0000_0100, rand_line(),
               128'h00000044_00000033_00000022_00000011, 100, 100, 0, 0, -1, -1);
        // dirty miss, always-ready
        run_op(1'b1, 1'b1, 0, 32'h0000_0200, 32'h0000_0400,
               128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, rand_line(), 100, 100, 0, 0, -1, -1);
        // pending commit for 5 cycles
        run_op(1'b1, 1'b1, 5, 32'h0000_0500, 32'h0000_0600, rand_line(), rand_line(),
               100, 100, 0, 0, -1, -1);
        // ready low 3 cycles on beat 2
        run_op(1'b1, 1'b1, 0, 32'h0000_0700, 32'h0000_0800, rand_line(), rand_line(),
               100, 100, 0, 0, 2, -1);
        // reset during fill after 2 beats, then a fresh operation
        run_op(1'b1, 1'b0, 0, 32'h0000_0900, 32'h0000_0A00, rand_line(), rand_line(),
               100, 100, 0, 0, -1, 2);
        run_op(1'b1, 1'b0, 0, 32'h0000_0B00, 32'h0000_0C00, rand_line(), rand_line(),
               100, 100, 0, 0, -1, -1);
        // evict_req held plus stray responses during writeback
        run_op(1'b1, 1'b1, 0, 32'h0000_0D00, 32'h0000_0E00, rand_line(), rand_line(),
               100, 100, 1, 1, -1, -1);

        for (int i = 0; i < 40; i++) begin
            run_op(1'($urandom_range(1)), 1'($urandom_range(1)), int'($urandom_range(3)),
                   $urandom & 32'hFFFF_FFF0, $urandom & 32'hFFFF_FFF0,
                   rand_line(), rand_line(),
                   int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                   1'($urandom_range(1)), 1'($urandom_range(1)), -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
